// File: rtl/inst_fetch_queue.sv
// Instruction fetch front-end. It issues word-aligned fetches to a 1-cycle
// synchronous instruction memory and buffers the returned words in a
// show-ahead prefetch FIFO. The CPU consumes instruction/PC pairs over a
// valid/ready handshake and can redirect fetch on taken branches or jumps.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_rvalid,
  input  logic [31:0]              imem_rdata,
  output logic                     inst_valid,
  output logic [31:0]              inst_data,
  output logic [31:0]              inst_pc,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned CRW  = CW + 1;

  // One FIFO slot: fetched word plus the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
  } entry_t;

  // Control state
  logic            run_q;
  logic            inflight_q;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q,   req_pc_d;

  // FIFO state
  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  // Internal handshake strobes
  logic            credit_ok;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redirect_tgt;
  entry_t          head;
  entry_t          push_entry;

  // Request gating, response acceptance and head presentation.
  always_comb begin
    credit_ok    = ({1'b0, count_q} + CRW'(inflight_q)) < CRW'(DEPTH);
    redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    imem_req     = run_q && !redirect && credit_ok;
    imem_addr    = fetch_pc_q;
    // Only a response to a request we actually issued is accepted; this
    // drops stale returns that straddle a reset.
    push         = imem_rvalid && inflight_q && !redirect;
    inst_valid   = (count_q != '0);
    pop          = inst_valid && inst_ready && !redirect;
    head         = mem_q[rd_ptr_q];
    inst_data    = inst_valid ? head.data : '0;
    inst_pc      = inst_valid ? head.pc   : '0;
    queue_count  = count_q;
    push_entry   = '{data: imem_rdata, pc: req_pc_q};
  end

  // Next-state for fetch PC, request PC capture and FIFO pointers.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (imem_req) begin
      req_pc_d = fetch_pc_q;
    end

    if (redirect) begin
      // Redirect wins over every other update: flush and retarget.
      fetch_pc_d = redirect_tgt;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (imem_req) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control and pointer registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      inflight_q <= 1'b0;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= imem_req;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents are masked at the outputs while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a 1-cycle memory whose word at A is A.
module tb_inst_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [2:0]  queue_count;

  int          n_cmp;
  int          n_err;
  int          req_cnt;
  logic [31:0] log_pc [$];

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .queue_count (queue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: one-cycle latency, word at address A reads as A.
  always @(posedge clk) begin
    imem_rvalid <= imem_req;
    imem_rdata  <= imem_addr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: apply inputs at the falling edge, settle, log deliveries.
  task automatic drive(input logic redir, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    redirect    = redir;
    redirect_pc = rpc;
    inst_ready  = rdy;
    #1;
    if (imem_req) req_cnt++;
    if (inst_valid && inst_ready && !redirect) begin
      log_pc.push_back(inst_pc);
      chk("data_eq_pc", inst_data, inst_pc);
    end
    if (imem_rvalid && !redirect)
      chk("no_push_full", 32'(32'(queue_count) < DEPTH), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    inst_ready  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; req_cnt = 0;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    #1;
    chk("rst_req",   32'(imem_req),    32'd0);
    chk("rst_addr",  imem_addr,        32'h0);
    chk("rst_valid", 32'(inst_valid),  32'd0);
    chk("rst_data",  inst_data,        32'h0);
    chk("rst_pc",    inst_pc,          32'h0);
    chk("rst_count", 32'(queue_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming with ready high: one instruction per cycle from cycle 3.
    for (int c = 1; c <= 8; c++) begin
      drive(1'b0, 32'h0, 1'b1);
      chk("t1_req",   32'(imem_req),   32'd1);
      chk("t1_addr",  imem_addr,       32'(4 * (c - 1)));
      chk("t1_valid", 32'(inst_valid), (c >= 3) ? 32'd1 : 32'd0);
      if (c >= 3) begin
        chk("t1_pc",    inst_pc,          32'(4 * (c - 3)));
        chk("t1_count", 32'(queue_count), 32'd1);
      end
    end

    // Ready low: exactly DEPTH requests, then the queue stalls full.
    do_reset();
    req_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      drive(1'b0, 32'h0, 1'b0);
      if (c <= 4) chk("t2_addr", imem_addr, 32'(4 * (c - 1)));
    end
    chk("t2_reqs",  32'(req_cnt),      32'd4);
    chk("t2_valid", 32'(inst_valid),   32'd1);
    chk("t2_count", 32'(queue_count),  32'd4);
    chk("t2_req",   32'(imem_req),     32'd0);
    chk("t2_head",  inst_pc,           32'h0);
    log_pc.delete();
    for (int c = 1; c <= 8; c++) begin
      drive(1'b0, 32'h0, 1'b1);
      chk("t2_nogap", 32'(inst_valid), 32'd1);
    end
    chk("t2_nlog", 32'(log_pc.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk("t2_seq", log_pc[i], 32'(4 * i));

    // Redirect with 3 queued entries and a response returning.
    do_reset();
    for (int c = 1; c <= 4; c++) drive(1'b0, 32'h0, 1'b0);
    drive(1'b1, 32'h0000_0103, 1'b1);
    chk("t3_req_sup", 32'(imem_req),    32'd0);
    chk("t3_count3",  32'(queue_count), 32'd3);
    chk("t3_rvalid",  32'(imem_rvalid), 32'd1);
    log_pc.delete();
    drive(1'b0, 32'h0, 1'b1);
    chk("t3_flush",  32'(queue_count), 32'd0);
    chk("t3_valid0", 32'(inst_valid),  32'd0);
    chk("t3_addr",   imem_addr,        32'h0000_0100);
    chk("t3_req",    32'(imem_req),    32'd1);
    drive(1'b0, 32'h0, 1'b1);
    chk("t3_addr2",  imem_addr,        32'h0000_0104);
    chk("t3_valid1", 32'(inst_valid),  32'd0);
    drive(1'b0, 32'h0, 1'b1);
    chk("t3_valid2", 32'(inst_valid),  32'd1);
    chk("t3_pc",     inst_pc,          32'h0000_0100);
    drive(1'b0, 32'h0, 1'b1);
    chk("t3_pc2",    inst_pc,          32'h0000_0104);
    chk("t3_first",  log_pc[0],        32'h0000_0100);

    // Back-to-back redirects: the second target wins.
    log_pc.delete();
    drive(1'b1, 32'h0000_0200, 1'b1);
    chk("t4_req1", 32'(imem_req), 32'd0);
    drive(1'b1, 32'h0000_0300, 1'b1);
    chk("t4_req2", 32'(imem_req), 32'd0);
    drive(1'b0, 32'h0, 1'b1);
    chk("t4_addr", imem_addr, 32'h0000_0300);
    for (int c = 1; c <= 5; c++) drive(1'b0, 32'h0, 1'b1);
    chk("t4_nlog", 32'(log_pc.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t4_seq", log_pc[i], 32'h0000_0300 + 32'(4 * i));

    // Redirect near the top of the address space: fetch PC wraps.
    log_pc.delete();
    drive(1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      drive(1'b0, 32'h0, 1'b1);
      chk("t5_addr", imem_addr, 32'hFFFF_FFF8 + 32'(4 * (k - 1)));
    end
    chk("t5_nlog", 32'(log_pc.size()), 32'd4);
    chk("t5_pc0",  log_pc[0], 32'hFFFF_FFF8);
    chk("t5_pc1",  log_pc[1], 32'hFFFF_FFFC);
    chk("t5_pc2",  log_pc[2], 32'h0000_0000);
    chk("t5_pc3",  log_pc[3], 32'h0000_0004);

    // Asynchronous reset pulse between clock edges mid-stream.
    #1 rst_n = 1'b0;
    #1;
    chk("t6_req",   32'(imem_req),    32'd0);
    chk("t6_valid", 32'(inst_valid),  32'd0);
    chk("t6_count", 32'(queue_count), 32'd0);
    chk("t6_pc",    inst_pc,          32'h0);
    chk("t6_data",  inst_data,        32'h0);
    chk("t6_addr",  imem_addr,        32'h0);
    rst_n = 1'b1;
    log_pc.delete();
    for (int c = 1; c <= 6; c++) begin
      drive(1'b0, 32'h0, 1'b1);
      chk("t6_raddr", imem_addr, 32'(4 * (c - 1)));
      if (c <= 2) chk("t6_empty", 32'(queue_count), 32'd0);
    end
    chk("t6_nlog", 32'(log_pc.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t6_seq", log_pc[i], 32'(4 * i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
